// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-N up/down counter with variable step, wrap/saturate modes and load.
module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              enable,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic              sat,
  output logic              load_err
);
  localparam int AW = (WIDTH > STEP_W ? WIDTH : STEP_W) + 1;
  localparam logic [AW-1:0] M = AW'(MODULUS);
  logic [WIDTH-1:0] count_q, count_d;
  logic wrap_q, wrap_d, sat_q, sat_d, lerr_q, lerr_d;
  logic [AW-1:0] c, s, lv, sum, dn;
  logic over, under, hit;
  // one extra bit over the wider operand keeps count+step and count+M-step from overflowing
  always_comb begin
    c = AW'(count_q);
    s = AW'(step) % M;
    lv = AW'(load_val) % M;
    sum = c + s;
    over = sum >= M;
    under = c < s;
    dn = under ? c + M - s : c - s;
    hit = up_down ? over : under;
    count_d = count_q;
    wrap_d = 1'b0;
    sat_d = 1'b0;
    lerr_d = 1'b0;
    if (load) begin
      count_d = WIDTH'(lv);
      lerr_d = AW'(load_val) >= M;
    end else if (enable && s != '0) begin
      if (hit && sat_mode) begin
        count_d = up_down ? WIDTH'(M - 1'b1) : '0;
        sat_d = 1'b1;
      end else begin
        count_d = up_down ? WIDTH'(over ? sum - M : sum) : WIDTH'(dn);
        wrap_d = hit;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q <= 1'b0;
      sat_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q <= wrap_d;
      sat_q <= sat_d;
      lerr_q <= lerr_d;
    end
  end
  assign count = count_q;
  assign wrap = wrap_q;
  assign sat = sat_q;
  assign load_err = lerr_q;
  assign tc = up_down ? (AW'(count_q) == M - 1'b1) : (count_q == '0);
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: random and directed stimulus checked against an arithmetic reference model.
module tb_mod_n_updown_counter;
  localparam int W = 4, MOD = 12, SW = 4;
  logic clk = 0, rst, load, enable, up_down, sat_mode;
  logic [W-1:0] load_val;
  logic [SW-1:0] step;
  logic [W-1:0] count;
  logic tc, wrap, sat, load_err;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  bit m_wrap, m_sat, m_lerr;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(W), .MODULUS(MOD), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .enable(enable),
    .up_down(up_down), .step(step), .sat_mode(sat_mode), .count(count),
    .tc(tc), .wrap(wrap), .sat(sat), .load_err(load_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit l, input int lv, input bit en,
                       input bit ud, input int st, input bit sm);
    rst = r; load = l; load_val = W'(lv); enable = en;
    up_down = ud; step = SW'(st); sat_mode = sm;
  endtask

  // model next state from the rules in plain integer arithmetic, then compare after the edge
  task automatic cyc();
    int s, t;
    m_wrap = 0; m_sat = 0; m_lerr = 0;
    if (rst) m_cnt = 0;
    else if (load) begin
      m_cnt = int'(load_val) % MOD;
      m_lerr = int'(load_val) >= MOD;
    end else if (enable) begin
      s = int'(step) % MOD;
      if (s != 0) begin
        t = up_down ? m_cnt + s : m_cnt - s;
        if (t >= 0 && t < MOD) m_cnt = t;
        else if (sat_mode) begin
          m_cnt = up_down ? MOD - 1 : 0;
          m_sat = 1;
        end else begin
          m_cnt = up_down ? t - MOD : t + MOD;
          m_wrap = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("count", int'(count), m_cnt);
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("sat", int'(sat), int'(m_sat));
    chk("load_err", int'(load_err), int'(m_lerr));
    chk("tc", int'(tc), int'(up_down ? m_cnt == MOD - 1 : m_cnt == 0));
  endtask

  initial begin
    drive(1, 1, 5, 1, 1, 1, 0);
    cyc(); cyc();
    chk("rst_count", int'(count), 0);
    chk("rst_flags", int'({wrap, sat, load_err}), 0);
    drive(0, 1, 11, 0, 1, 1, 0); cyc();
    chk("tc_at_11_up", int'(tc), 1);
    drive(0, 0, 0, 1, 1, 1, 0); cyc();
    chk("upwrap_count", int'(count), 0);
    chk("upwrap_pulse", int'(wrap), 1);
    cyc();
    chk("upwrap_next", int'(count), 1);
    chk("upwrap_clear", int'(wrap), 0);
    drive(0, 1, 2, 0, 0, 5, 0); cyc();
    drive(0, 0, 0, 1, 0, 5, 0); cyc();
    chk("dnwrap_count", int'(count), 9);
    chk("dnwrap_pulse", int'(wrap), 1);
    drive(0, 1, 2, 0, 0, 5, 1); cyc();
    drive(0, 0, 0, 1, 0, 5, 1); cyc();
    chk("dnsat_count", int'(count), 0);
    chk("dnsat_pulse", int'(sat), 1);
    cyc();
    chk("dnsat_again", int'({28'd0, count} + (sat ? 100 : 0)), 100);
    drive(0, 1, 14, 0, 1, 0, 0); cyc();
    chk("oor_load_count", int'(count), 2);
    chk("oor_load_err", int'(load_err), 1);
    drive(0, 1, 11, 0, 1, 0, 0); cyc();
    chk("inrange_load_err", int'(load_err), 0);
    drive(0, 1, 7, 1, 1, 3, 0); cyc();
    chk("load_over_enable", int'(count), 7);
    drive(1, 1, 7, 1, 1, 3, 0); cyc();
    chk("rst_over_load", int'(count), 0);
    drive(0, 1, 4, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 1, 1, 0, 0); cyc();
    chk("step0_count", int'(count), 4);
    chk("step0_flags", int'({wrap, sat, load_err}), 0);
    drive(0, 0, 0, 1, 1, 13, 0); cyc();
    chk("step13_count", int'(count), 5);
    drive(0, 1, 11, 0, 1, 0, 1); cyc();
    drive(0, 0, 0, 1, 1, 2, 1); cyc();
    chk("upsat_count", int'(count), 11);
    cyc();
    chk("upsat_again", int'(sat), 1);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15, $urandom_range(0, 15),
            $urandom_range(0, 99) < 80, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 1));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
